// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ==========================================================================
// pc_unit_pkg : shared processor types and defaults for the PC unit | rev 1.0
// ==========================================================================
package pc_unit_pkg;

  localparam int DEF_PC_WIDTH  = 10;
  localparam int DEF_LUT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ==========================================================================
// pc_unit_if : control, branch, LUT-load and status bundle of pc_unit | rev 1.0
// ==========================================================================
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int LUT_DEPTH = DEF_LUT_DEPTH
);
  localparam int IDX_W = $clog2(LUT_DEPTH);

  logic                start;
  logic                stall;
  logic                halt_req;
  logic                branch;
  logic [7:0]          branch_val;
  logic [IDX_W-1:0]    lut_idx;
  logic                lut_we;
  logic [IDX_W-1:0]    lut_waddr;
  logic [PC_WIDTH-1:0] lut_wdata;
  logic [PC_WIDTH-1:0] pc;
  logic                running;
  logic                done;
  logic [7:0]          taken_cnt;

  modport master (
    output start, stall, halt_req, branch, branch_val, lut_idx,
           lut_we, lut_waddr, lut_wdata,
    input  pc, running, done, taken_cnt
  );

  modport slave (
    input  start, stall, halt_req, branch, branch_val, lut_idx,
           lut_we, lut_waddr, lut_wdata,
    output pc, running, done, taken_cnt
  );

endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_unit_branch_lut.sv
`default_nettype none
// ==========================================================================
// branch_lut : branch-target table, synchronous write / asynchronous read | rev 1.0
// ==========================================================================
module branch_lut #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  we,
  input  wire logic [IDX_W-1:0]      waddr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  input  wire logic [IDX_W-1:0]      raddr,
  output logic      [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[g] <= '0;
      end else if (we && (waddr == IDX_W'(g))) begin
        r_mem[g] <= wdata;
      end
    end
  end

  // Read is combinational, so a same-cycle write is only seen next cycle.
  assign rdata = r_mem[raddr];

endmodule : branch_lut
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ==========================================================================
// pc_unit : program counter with IDLE/RUN/HALT control and branch LUT | rev 1.0
// ==========================================================================
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
  parameter int                  LUT_DEPTH  = DEF_LUT_DEPTH,
  parameter logic [PC_WIDTH-1:0] START_ADDR = '0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  pc_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  pc_state_t           r_state;
  pc_state_t           w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [7:0]          r_taken_cnt;
  logic [7:0]          w_cnt_next;
  logic [PC_WIDTH-1:0] w_lut_target;
  logic                w_taken;
  logic                w_advance;
  logic                w_unused_val_bits;

  branch_lut #(
    .DATA_WIDTH (PC_WIDTH),
    .DEPTH      (LUT_DEPTH),
    .IDX_W      (IDX_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.lut_we),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.lut_idx),
    .rdata (w_lut_target)
  );

  // Only the condition bit of the execute result steers the branch.
  assign w_taken           = bus.branch & bus.branch_val[0];
  assign w_unused_val_bits = ^bus.branch_val[7:1];
  assign w_advance         = (r_state == ST_RUN) && !bus.stall && !bus.halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (!bus.stall && bus.halt_req) w_state_next = ST_HALT;
      ST_HALT: if (bus.start) w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.running = (r_state == ST_RUN);
    bus.done    = (r_state == ST_HALT);
  end

  always_comb begin
    w_pc_next  = r_pc;
    w_cnt_next = r_taken_cnt;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_pc_next  = START_ADDR;
          w_cnt_next = 8'd0;
        end
      end
      ST_RUN: begin
        if (w_advance) begin
          if (w_taken) begin
            w_pc_next  = w_lut_target;
            w_cnt_next = sat_inc8(r_taken_cnt);
          end else begin
            w_pc_next  = r_pc + c_pc_one;
          end
        end
      end
      default: begin
        w_pc_next  = START_ADDR;
        w_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= START_ADDR;
      r_taken_cnt <= 8'd0;
    end else begin
      r_pc        <= w_pc_next;
      r_taken_cnt <= w_cnt_next;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.taken_cnt = r_taken_cnt;

endmodule : pc_unit
`default_nettype wire
